// File: rtl/ss_wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state
// encodings and default beat limits.
package ss_wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN0    = 2'd1,
        ST_OWN1    = 2'd2,
        ST_PREEMPT = 2'd3
    } state_e;

    localparam int MAX_BEATS_DEF = 16;
    localparam int CNT_W_DEF     = 5;

endpackage

// File: rtl/ss_wb_arb_rr.sv
// Two-way round-robin pick: on a tie the master that did not own the bus
// last wins. Output grant is one-hot (or zero when nothing is requested).
module ss_wb_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Grant selection from the request vector and the last-owner pointer
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ss_wb_arb.sv
// Two-master Wishbone arbiter sharing one bus between the read and write
// SG engines. An owner keeps the bus while it holds cyc; once it has
// completed MAX_BEATS acked beats and the other master waits, a non-burst
// strobe is answered with retry so the other engine gets its turn.
module ss_wb_arb
    import ss_wb_arb_pkg::*;
#(
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m0_cyc,
    input  logic        m1_cyc,
    input  logic        m0_stb,
    input  logic        m1_stb,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic        m0_cab,
    input  logic        m1_cab,
    input  logic [3:0]  m0_sel,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m1_adr,
    output logic [31:0] m0_dat_o,
    output logic [31:0] m1_dat_o,
    output logic [31:0] m0_dat64_o,
    output logic [31:0] m1_dat64_o,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic        m0_err,
    output logic        m1_err,
    output logic        m0_rty,
    output logic        m1_rty,
    output logic        wbs_cyc,
    output logic        wbs_stb,
    output logic        wbs_we,
    output logic        wbs_cab,
    output logic [3:0]  wbs_sel,
    output logic [31:0] wbs_adr,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_dat64_i,
    input  logic        wbs_ack,
    input  logic        wbs_err,
    input  logic        wbs_rty,
    output logic [1:0]  gnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_r;
    state_e           state_nxt_s;
    logic             last_r;
    logic             last_nxt_s;
    logic [1:0]       gnt_r;
    logic [1:0]       gnt_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [1:0]       rr_gnt_s;

    logic             own_s;
    logic             own_st_s;
    logic             sel_cyc_s;
    logic             sel_stb_s;
    logic             sel_cab_s;
    logic             oth_cyc_s;
    logic             preempt_s;
    logic             ack_s;
    logic             err_s;
    logic             rty_s;

    ss_wb_arb_rr u_rr (
        .req  ({m1_cyc, m0_cyc}),
        .last (last_r),
        .gnt  (rr_gnt_s)
    );

    // Owner index follows the registered grant; gnt_r[1] set means m1 owns
    assign own_s     = gnt_r[1];
    assign own_st_s  = (state_r == ST_OWN0) || (state_r == ST_OWN1);
    assign sel_cyc_s = own_s ? m1_cyc : m0_cyc;
    assign sel_stb_s = own_s ? m1_stb : m0_stb;
    assign sel_cab_s = own_s ? m1_cab : m0_cab;
    assign oth_cyc_s = own_s ? m0_cyc : m1_cyc;

    // An ack landing in the limit cycle is delivered; retry waits for the next beat
    assign preempt_s = own_st_s && sel_cyc_s && sel_stb_s && !sel_cab_s &&
                       oth_cyc_s && (cnt_r == MAX_CNT) && !wbs_ack;

    // Shared-bus mux and per-owner response generation
    always_comb begin
        wbs_cyc = 1'b0;
        wbs_stb = 1'b0;
        wbs_we  = 1'b0;
        wbs_cab = 1'b0;
        wbs_sel = 4'h0;
        wbs_adr = 32'h0000_0000;
        ack_s   = 1'b0;
        err_s   = 1'b0;
        rty_s   = 1'b0;
        case (state_r)
            ST_OWN0, ST_OWN1: begin
                wbs_cyc = sel_cyc_s;
                wbs_stb = sel_stb_s & ~preempt_s;
                wbs_we  = own_s ? m1_we  : m0_we;
                wbs_cab = sel_cab_s;
                wbs_sel = own_s ? m1_sel : m0_sel;
                wbs_adr = own_s ? m1_adr : m0_adr;
                ack_s   = wbs_ack;
                err_s   = wbs_err;
                rty_s   = wbs_rty | preempt_s;
            end
            ST_PREEMPT: begin
                rty_s   = sel_stb_s;
            end
            default: begin
                rty_s   = 1'b0;
            end
        endcase
    end

    assign m0_ack     = ack_s & ~own_s;
    assign m1_ack     = ack_s &  own_s;
    assign m0_err     = err_s & ~own_s;
    assign m1_err     = err_s &  own_s;
    assign m0_rty     = rty_s & ~own_s;
    assign m1_rty     = rty_s &  own_s;
    assign m0_dat_o   = wbs_dat_i;
    assign m1_dat_o   = wbs_dat_i;
    assign m0_dat64_o = wbs_dat64_i;
    assign m1_dat64_o = wbs_dat64_i;
    assign gnt        = gnt_r;

    // Next-state, grant, round-robin pointer and beat-count computation
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        last_nxt_s  = last_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (rr_gnt_s[0]) begin
                    state_nxt_s = ST_OWN0;
                    gnt_nxt_s   = 2'b01;
                end else if (rr_gnt_s[1]) begin
                    state_nxt_s = ST_OWN1;
                    gnt_nxt_s   = 2'b10;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!sel_cyc_s) begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = 2'b00;
                    last_nxt_s  = own_s;
                    cnt_nxt_s   = '0;
                end else begin
                    if (preempt_s) begin
                        state_nxt_s = ST_PREEMPT;
                    end else begin
                        state_nxt_s = state_r;
                    end
                    if (wbs_ack && wbs_stb && (cnt_r != MAX_CNT)) begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
            end
            ST_PREEMPT: begin
                if (!sel_cyc_s) begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = 2'b00;
                    last_nxt_s  = own_s;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_PREEMPT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = 2'b00;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Arbiter state registers; pointer resets to m1 so m0 wins the first tie
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_r <= ST_IDLE;
            gnt_r   <= 2'b00;
            last_r  <= 1'b1;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            last_r  <= last_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_ss_wb_arb.sv
// Directed bench for ss_wb_arb (MAX_BEATS=4). Stimulus pushes the expected
// bus/response picture for each cycle into a queue; a monitor compares it
// against the DUT on the falling edge.
module tb_ss_wb_arb;

    localparam logic [31:0] DLO = 32'hDEAD_BEEF;
    localparam logic [31:0] DHI = 32'h0123_4567;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m1_cyc, m0_stb, m1_stb, m0_we, m1_we, m0_cab, m1_cab;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_adr, m1_adr;
    logic [31:0] m0_dat_o, m1_dat_o, m0_dat64_o, m1_dat64_o;
    logic        m0_ack, m1_ack, m0_err, m1_err, m0_rty, m1_rty;
    logic        wbs_cyc, wbs_stb, wbs_we, wbs_cab;
    logic [3:0]  wbs_sel;
    logic [31:0] wbs_adr;
    logic [31:0] wbs_dat_i, wbs_dat64_i;
    logic        wbs_ack, wbs_err, wbs_rty;
    logic [1:0]  gnt;

    typedef struct {
        string        name;
        logic [105:0] v;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ss_wb_arb #(.MAX_BEATS(4), .CNT_W(3)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .m0_cyc      (m0_cyc),
        .m1_cyc      (m1_cyc),
        .m0_stb      (m0_stb),
        .m1_stb      (m1_stb),
        .m0_we       (m0_we),
        .m1_we       (m1_we),
        .m0_cab      (m0_cab),
        .m1_cab      (m1_cab),
        .m0_sel      (m0_sel),
        .m1_sel      (m1_sel),
        .m0_adr      (m0_adr),
        .m1_adr      (m1_adr),
        .m0_dat_o    (m0_dat_o),
        .m1_dat_o    (m1_dat_o),
        .m0_dat64_o  (m0_dat64_o),
        .m1_dat64_o  (m1_dat64_o),
        .m0_ack      (m0_ack),
        .m1_ack      (m1_ack),
        .m0_err      (m0_err),
        .m1_err      (m1_err),
        .m0_rty      (m0_rty),
        .m1_rty      (m1_rty),
        .wbs_cyc     (wbs_cyc),
        .wbs_stb     (wbs_stb),
        .wbs_we      (wbs_we),
        .wbs_cab     (wbs_cab),
        .wbs_sel     (wbs_sel),
        .wbs_adr     (wbs_adr),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_dat64_i (wbs_dat64_i),
        .wbs_ack     (wbs_ack),
        .wbs_err     (wbs_err),
        .wbs_rty     (wbs_rty),
        .gnt         (gnt)
    );

    // Expected picture: {gnt, wbs_cyc, wbs_stb, m0 ack/err/rty, m1 ack/err/rty, wbs_adr, m0_dat_o, m1_dat64_o}
    task automatic ex(input string n, input logic [1:0] g, input logic c, input logic s,
                      input logic [31:0] a, input logic [2:0] r0, input logic [2:0] r1);
        exp_t e;
        e.name = n;
        e.v    = {g, c, s, r0, r1, a, DLO, DHI};
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m0s(input logic c, input logic s, input logic cab, input logic [31:0] a);
        m0_cyc = c; m0_stb = s; m0_cab = cab; m0_adr = a;
    endtask

    task automatic m1s(input logic c, input logic s, input logic cab, input logic [31:0] a);
        m1_cyc = c; m1_stb = s; m1_cab = cab; m1_adr = a;
    endtask

    task automatic sl(input logic ack, input logic err, input logic rty);
        wbs_ack = ack; wbs_err = err; wbs_rty = rty;
    endtask

    // Monitor: compare every queued expectation against the DUT on the falling edge
    initial begin
        logic [105:0] act;
        exp_t         e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = {gnt, wbs_cyc, wbs_stb, m0_ack, m0_err, m0_rty,
                       m1_ack, m1_err, m1_rty, wbs_adr, m0_dat_o, m1_dat64_o};
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL %s: actual=%h required=%h (t=%0t)", e.name, act, e.v, $time);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        rst_n = 1'b0;
        m0_we = 1'b0; m1_we = 1'b1; m0_sel = 4'hF; m1_sel = 4'h3;
        m0s(1'b0, 1'b0, 1'b0, 32'h0); m1s(1'b0, 1'b0, 1'b0, 32'h0);
        sl(1'b0, 1'b0, 1'b0);
        wbs_dat_i = DLO; wbs_dat64_i = DHI;
        ex("reset", 2'b00, 1'b0, 1'b0, 32'h0, 3'b000, 3'b000);
        tick();
        tick();
        // Tie in the same cycle: m0 wins after one idle clock
        rst_n = 1'b1;
        m0s(1'b1, 1'b0, 1'b0, 32'h0); m1s(1'b1, 1'b1, 1'b0, 32'h200);
        ex("tie_idle", 2'b00, 1'b0, 1'b0, 32'h0, 3'b000, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            m0s(1'b1, 1'b1, 1'b0, 32'h100 + 32'(4 * i)); sl(1'b1, 1'b0, 1'b0);
            ex("m0_read", 2'b01, 1'b1, 1'b1, 32'h100 + 32'(4 * i), 3'b100, 3'b000);
        end
        tick();
        m0s(1'b0, 1'b0, 1'b0, 32'h108); sl(1'b0, 1'b0, 1'b0);
        ex("m0_drop", 2'b01, 1'b0, 1'b0, 32'h108, 3'b000, 3'b000);
        // m0 re-raises in the idle clock and loses to waiting m1
        tick();
        m0s(1'b1, 1'b0, 1'b0, 32'h300);
        ex("rr_idle", 2'b00, 1'b0, 1'b0, 32'h0, 3'b000, 3'b000);
        tick();
        sl(1'b1, 1'b0, 1'b0);
        ex("m1_gnt", 2'b10, 1'b1, 1'b1, 32'h200, 3'b000, 3'b100);
        tick();
        m1s(1'b1, 1'b1, 1'b0, 32'h204); sl(1'b0, 1'b1, 1'b0);
        ex("m1_err", 2'b10, 1'b1, 1'b1, 32'h204, 3'b000, 3'b010);
        for (int i = 0; i < 2; i++) begin
            tick();
            m1s(1'b1, 1'b1, 1'b0, 32'h208 + 32'(4 * i)); sl(1'b1, 1'b0, 1'b0);
            ex("m1_beat", 2'b10, 1'b1, 1'b1, 32'h208 + 32'(4 * i), 3'b000, 3'b100);
        end
        // Three acked beats so far (err not counted): a wait state is not pre-empted
        tick();
        m1s(1'b1, 1'b1, 1'b0, 32'h210); sl(1'b0, 1'b0, 1'b0);
        ex("m1_wait", 2'b10, 1'b1, 1'b1, 32'h210, 3'b000, 3'b000);
        tick();
        sl(1'b1, 1'b0, 1'b0);
        ex("m1_ack4", 2'b10, 1'b1, 1'b1, 32'h210, 3'b000, 3'b100);
        // At the limit, an ack in the same cycle is still delivered
        tick();
        m1s(1'b1, 1'b1, 1'b0, 32'h214);
        ex("ack_wins", 2'b10, 1'b1, 1'b1, 32'h214, 3'b000, 3'b100);
        tick();
        m1s(1'b1, 1'b1, 1'b0, 32'h218); sl(1'b0, 1'b0, 1'b0);
        ex("m1_pre", 2'b10, 1'b1, 1'b0, 32'h218, 3'b000, 3'b001);
        tick();
        ex("m1_preempt_st", 2'b10, 1'b0, 1'b0, 32'h0, 3'b000, 3'b001);
        tick();
        m1s(1'b0, 1'b0, 1'b0, 32'h218);
        ex("m1_release", 2'b10, 1'b0, 1'b0, 32'h0, 3'b000, 3'b000);
        tick();
        m1s(1'b1, 1'b0, 1'b0, 32'h400);
        ex("idle2", 2'b00, 1'b0, 1'b0, 32'h0, 3'b000, 3'b000);
        // 20-beat cab burst with m1 waiting: never retried
        for (int i = 0; i < 20; i++) begin
            tick();
            m0s(1'b1, 1'b1, 1'b1, 32'h1000 + 32'(4 * i)); sl(1'b1, 1'b0, 1'b0);
            ex("cab_beat", 2'b01, 1'b1, 1'b1, 32'h1000 + 32'(4 * i), 3'b100, 3'b000);
        end
        tick();
        m0s(1'b0, 1'b0, 1'b0, 32'h104C); sl(1'b0, 1'b0, 1'b0);
        ex("cab_drop", 2'b01, 1'b0, 1'b0, 32'h104C, 3'b000, 3'b000);
        tick();
        ex("idle3", 2'b00, 1'b0, 1'b0, 32'h0, 3'b000, 3'b000);
        tick();
        m0s(1'b1, 1'b0, 1'b0, 32'h500);
        ex("m1_gnt2", 2'b10, 1'b1, 1'b0, 32'h400, 3'b000, 3'b000);
        tick();
        m1s(1'b0, 1'b0, 1'b0, 32'h400);
        ex("m1_drop2", 2'b10, 1'b0, 1'b0, 32'h400, 3'b000, 3'b000);
        tick();
        m1s(1'b1, 1'b0, 1'b0, 32'h600);
        ex("idle4", 2'b00, 1'b0, 1'b0, 32'h0, 3'b000, 3'b000);
        // Non-cab reads by m0 with m1 requesting: 5th strobe is retried
        for (int i = 0; i < 4; i++) begin
            tick();
            m0s(1'b1, 1'b1, 1'b0, 32'h500 + 32'(4 * i)); sl(1'b1, 1'b0, 1'b0);
            ex("m0_nc", 2'b01, 1'b1, 1'b1, 32'h500 + 32'(4 * i), 3'b100, 3'b000);
        end
        tick();
        m0s(1'b1, 1'b1, 1'b0, 32'h510); sl(1'b0, 1'b0, 1'b0);
        ex("m0_pre", 2'b01, 1'b1, 1'b0, 32'h510, 3'b001, 3'b000);
        tick();
        ex("m0_preempt_st", 2'b01, 1'b0, 1'b0, 32'h0, 3'b001, 3'b000);
        tick();
        m0s(1'b0, 1'b0, 1'b0, 32'h510);
        ex("m0_release", 2'b01, 1'b0, 1'b0, 32'h0, 3'b000, 3'b000);
        tick();
        ex("idle5", 2'b00, 1'b0, 1'b0, 32'h0, 3'b000, 3'b000);
        tick();
        m1s(1'b1, 1'b1, 1'b0, 32'h600); sl(1'b1, 1'b0, 1'b0);
        ex("m1_gnt3", 2'b10, 1'b1, 1'b1, 32'h600, 3'b000, 3'b100);
        // Asynchronous reset between edges mid-burst
        tick();
        m1s(1'b1, 1'b1, 1'b0, 32'h604); sl(1'b1, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        ex("async_rst", 2'b00, 1'b0, 1'b0, 32'h0, 3'b000, 3'b000);
        tick();
        rst_n = 1'b1;
        m0s(1'b1, 1'b0, 1'b0, 32'h700); sl(1'b0, 1'b0, 1'b0);
        ex("rst_idle", 2'b00, 1'b0, 1'b0, 32'h0, 3'b000, 3'b000);
        tick();
        ex("rst_tie", 2'b01, 1'b1, 1'b0, 32'h700, 3'b000, 3'b000);
        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ss_wb_arb.md
Name: ss_wb_arb

Overview:
- Two-master Wishbone arbiter; lets the read SG engine (m0) and the write SG engine (m1) share one Wishbone master port toward the PCI/host bridge.
- Sits between the two ss_sg instances and the bus.
- Round-robin grant; an owner keeps the bus while it holds cyc.
- A beat-count limit forces a retry so one burst cannot starve the other engine.

Parameters:
- MAX_BEATS, 16: acked beats an owner may complete before it is pre-empted, if the other master is requesting.
- CNT_W, 5: width of the beat counter; must satisfy 2^CNT_W > MAX_BEATS.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset, asynchronous, active-low
- m0_cyc, m1_cyc  in  1  master cycle request
- m0_stb, m1_stb  in  1  master strobe
- m0_we, m1_we  in  1  master write enable
- m0_cab, m1_cab  in  1  master burst (consecutive address) flag
- m0_sel, m1_sel  in  4  byte selects
- m0_adr, m1_adr  in  32  addresses
- m0_dat_o, m1_dat_o  out  32  read data, low word
- m0_dat64_o, m1_dat64_o  out  32  read data, high word
- m0_ack, m1_ack  out  1  acknowledge
- m0_err, m1_err  out  1  error
- m0_rty, m1_rty  out  1  retry
- wbs_cyc, wbs_stb, wbs_we, wbs_cab  out  1  shared bus controls
- wbs_sel  out  4  shared byte selects
- wbs_adr  out  32  shared address
- wbs_dat_i, wbs_dat64_i  in  32  slave read data
- wbs_ack, wbs_err, wbs_rty  in  1  slave responses
- gnt  out  2  one-hot grant, status/debug

Behaviour:
- Reset (wb_rst_i=0, asynchronous):
  - gnt=00, state IDLE, beat count 0, preempt flag 0.
  - Round-robin pointer last=1, so m0 wins the first tie.
  - All wbs_* controls and all m*_ack/err/rty are 0.
- FSM states: IDLE, OWN0, OWN1, PREEMPT.
- IDLE:
  - Exactly one cyc high: go to that master's OWN state at the next edge.
  - Both cyc high: grant the master that is not last.
  - Neither high: stay in IDLE.
  - No bus activity in IDLE; grant latency is 1 clock from cyc to wbs_cyc.
- OWNx:
  - wbs_cyc/stb/we/cab/sel/adr = mx signals, combinationally.
  - mx_ack/err/rty = wbs_ack/err/rty.
  - The other master sees ack/err/rty = 0.
  - Read data (dat_o, dat64_o) is broadcast to both masters.
- Leaving OWNx:
  - mx_cyc falls: go to IDLE at the next edge, set last=x, clear the count.
  - Re-arbitration therefore takes 1 idle clock between owners.
- Beat counter:
  - Increments on wbs_ack & wbs_stb in OWNx and saturates at MAX_BEATS.
  - err and rty beats are not counted.
- Pre-emption:
  - Condition: count==MAX_BEATS, other cyc=1, mx_stb=1, mx_cab=0. A cab burst is never broken.
  - In that cycle, wbs_stb is forced 0, mx_rty=1 for one clock, and the FSM enters PREEMPT.
  - If wbs_ack arrives in the same cycle as the condition, the ack is delivered and pre-emption is evaluated next beat.
- PREEMPT:
  - wbs_cyc=0; the owner sees rty=1 on every stb.
  - Owner drops cyc: go to IDLE with last=x, so the other master wins.
- Slave err/rty pass through unmodified and do not end ownership.
- Simultaneous events:
  - Owner drops cyc while the other raises cyc in the same cycle: handled normally through IDLE.
  - Owner re-raises cyc in the IDLE cycle after dropping it: loses the tie to a waiting other master.
- Reset asserted mid-transfer: all outputs drop to 0 asynchronously; the slave cycle is abandoned.

Decomposition:
- Shared package/header ss_defs: state encodings and the MAX_BEATS default.
- One sub-module is natural: ss_wb_arb_rr, a 2-way round-robin pick from req[1:0] and last, producing a one-hot grant.
- The mux and FSM stay in the top module.

Test Plan:
- Reset, then m0_cyc=m1_cyc=1 in the same cycle → gnt=01 after 1 clock; m1 sees no ack.
- m0 does 3 single reads (adr 0x100,0x104,0x108), drops cyc with m1 waiting → 1 idle clock, then gnt=10 and wbs_adr=m1_adr.
- MAX_BEATS=4, m0 does non-cab reads with m1 requesting → on the 5th stb: m0_rty=1, wbs_stb=0; after m0 drops cyc, gnt=10.
- m0 does a 20-beat cab=1 burst with m1 waiting → no rty during the burst; m1 is granted 1 clock after m0_cyc falls.
- Slave returns wbs_err on beat 2 of m1 → m1_err=1, m0_err=0, gnt stays 10, count not incremented.
- wb_rst_i pulled low mid-burst (async, between edges) → wbs_cyc=0 and gnt=00 immediately; after release, m0 is granted first on a tie.
